// File: rtl/buf_scanout_ctrl.sv
// buf_scanout_ctrl: read-side scan-out controller for two ping-pong pixel
// frame buffers. Walks the selected buffer in row-major order, emits a
// pixel stream framed by hsync/vsync and releases each buffer back to the
// writer through its empty flag once the scan of that buffer is done.
//
// Optional build macro: REPEAT_FRAME_EN
//   defined   - on underrun the current buffer is rescanned and kept
//   undefined - on underrun the buffer is released and the block idles
//
// Handshake: bufN_full is level-sampled; only a 0->1 transition marks the
// buffer as holding a fresh frame. bufN_empty = 1 means the writer owns
// buffer N; it drops to 0 the cycle a scan of that buffer begins and rises
// again the cycle after the SWAP that hands the buffer back.
//
// Frame timing: VBLANK lasts one cycle less than the blanking period because
// the single-cycle SWAP closes the vertical blanking interval. This keeps the
// frame at (H_ACTIVE+H_BLANK)*(V_ACTIVE+V_BLANK) cycles with back-to-back
// frames. UNDERRUN_MAX is the saturation value of underrun_cnt.
module buf_scanout_ctrl #(
  parameter int          H_ACTIVE     = 100,
  parameter int          V_ACTIVE     = 100,
  parameter int          H_BLANK      = 4,
  parameter int          V_BLANK      = 2,
  parameter int          ADDR_W       = 20,
  parameter logic [15:0] UNDERRUN_MAX = 16'hFFFF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              buf0_full,
  input  logic              buf1_full,
  input  logic [7:0]        r0,
  input  logic [7:0]        g0,
  input  logic [7:0]        b0,
  input  logic [7:0]        r1,
  input  logic [7:0]        g1,
  input  logic [7:0]        b1,
  output logic              re0,
  output logic              re1,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              buf0_empty,
  output logic              buf1_empty,
  output logic [7:0]        pix_r,
  output logic [7:0]        pix_g,
  output logic [7:0]        pix_b,
  output logic              pix_valid,
  output logic              hsync,
  output logic              vsync,
  output logic              frame_done,
  output logic [15:0]       underrun_cnt
);

  localparam int VB_CYC = V_BLANK * (H_ACTIVE + H_BLANK);

  typedef enum logic [2:0] {IDLE, ACTIVE, HBLANK, VBLANK, SWAP} state_t;

  state_t            state, state_n;
  logic              sel, sel_n;           // current buffer; doubles as last_sel
  logic              ready0, ready1;
  logic              prev0, prev1;
  logic              empty0_n, empty1_n;
  logic              clr0, clr1;
  logic              und_inc;
  logic [ADDR_W-1:0] addr, addr_n;
  logic [15:0]       cnt, cnt_n;
  logic [15:0]       y, y_n;
  logic              re_d1, sel_d1;

  // Moore outputs decoded from the scan state.
  assign re0        = (state == ACTIVE) && !sel;
  assign re1        = (state == ACTIVE) &&  sel;
  assign rd_addr    = (state == ACTIVE) ? addr : '0;
  assign hsync      = (state == HBLANK);
  assign vsync      = (state == VBLANK) || (state == SWAP);
  assign frame_done = (state == SWAP);

  // Next-state, counters, buffer selection and release decisions.
  always_comb begin
    state_n  = state;
    sel_n    = sel;
    addr_n   = addr;
    cnt_n    = cnt;
    y_n      = y;
    empty0_n = buf0_empty;
    empty1_n = buf1_empty;
    clr0     = 1'b0;
    clr1     = 1'b0;
    und_inc  = 1'b0;
    case (state)
      IDLE: begin
        if (ready0 || ready1) begin
          // Alternate when both are ready, otherwise take the ready one.
          sel_n   = (ready0 && ready1) ? ~sel : ready1;
          state_n = ACTIVE;
          addr_n  = '0;
          cnt_n   = '0;
          y_n     = '0;
          if (sel_n) begin
            clr1     = 1'b1;
            empty1_n = 1'b0;
          end else begin
            clr0     = 1'b1;
            empty0_n = 1'b0;
          end
        end
      end
      ACTIVE: begin
        addr_n = addr + ADDR_W'(1);
        if (cnt == 16'(H_ACTIVE - 1)) begin
          cnt_n   = '0;
          state_n = HBLANK;
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      HBLANK: begin
        if (cnt == 16'(H_BLANK - 1)) begin
          cnt_n   = '0;
          y_n     = y + 16'd1;
          state_n = ((y + 16'd1) < 16'(V_ACTIVE)) ? ACTIVE : VBLANK;
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      VBLANK: begin
        if (cnt == 16'(VB_CYC - 2)) begin
          cnt_n   = '0;
          state_n = SWAP;
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      SWAP: begin
        addr_n = '0;
        cnt_n  = '0;
        y_n    = '0;
        if (sel ? ready0 : ready1) begin
          sel_n   = ~sel;
          state_n = ACTIVE;
          if (sel) begin
            empty1_n = 1'b1;
            empty0_n = 1'b0;
            clr0     = 1'b1;
          end else begin
            empty0_n = 1'b1;
            empty1_n = 1'b0;
            clr1     = 1'b1;
          end
        end else begin
          und_inc = 1'b1;
`ifdef REPEAT_FRAME_EN
          state_n = ACTIVE;
`else
          state_n = IDLE;
          if (sel) empty1_n = 1'b1;
          else     empty0_n = 1'b1;
`endif
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Control state: FSM, counters, ready edge detectors, empty flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      sel          <= 1'b1;
      ready0       <= 1'b0;
      ready1       <= 1'b0;
      prev0        <= 1'b1;
      prev1        <= 1'b1;
      buf0_empty   <= 1'b1;
      buf1_empty   <= 1'b1;
      addr         <= '0;
      cnt          <= '0;
      y            <= '0;
      underrun_cnt <= '0;
    end else begin
      state      <= state_n;
      sel        <= sel_n;
      prev0      <= buf0_full;
      prev1      <= buf1_full;
      ready0     <= (ready0 | (buf0_full & ~prev0)) & ~clr0;
      ready1     <= (ready1 | (buf1_full & ~prev1)) & ~clr1;
      buf0_empty <= empty0_n;
      buf1_empty <= empty1_n;
      addr       <= addr_n;
      cnt        <= cnt_n;
      y          <= y_n;
      if (und_inc && (underrun_cnt != UNDERRUN_MAX))
        underrun_cnt <= underrun_cnt + 16'd1;
    end
  end

  // Read pipeline: data returns one cycle after re, registered the next.
  always_ff @(posedge clk) begin
    if (reset) begin
      re_d1     <= 1'b0;
      sel_d1    <= 1'b0;
      pix_valid <= 1'b0;
      pix_r     <= '0;
      pix_g     <= '0;
      pix_b     <= '0;
    end else begin
      re_d1     <= re0 | re1;
      sel_d1    <= sel;
      pix_valid <= re_d1;
      if (re_d1) begin
        pix_r <= sel_d1 ? r1 : r0;
        pix_g <= sel_d1 ? g1 : g0;
        pix_b <= sel_d1 ? b1 : b0;
      end
    end
  end

endmodule

// File: tb/tb_buf_scanout_ctrl.sv
// tb_buf_scanout_ctrl: checks buf_scanout_ctrl with a 4x2 active frame,
// 2-cycle horizontal and 1-line vertical blanking (18-cycle frames).
module tb_buf_scanout_ctrl;

`ifdef REPEAT_FRAME_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        buf0_full, buf1_full;
  logic [7:0]  r0, g0, b0, r1, g1, b1;
  logic        re0, re1;
  logic [19:0] rd_addr;
  logic        buf0_empty, buf1_empty;
  logic [7:0]  pix_r, pix_g, pix_b;
  logic        pix_valid, hsync, vsync, frame_done;
  logic [15:0] underrun_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  logic [23:0] exp_q[$];

  typedef struct {
    logic        re;
    logic [19:0] addr;
    logic        hs;
    logic        vs;
    logic        fd;
  } vec_t;
  vec_t fr[18];

  buf_scanout_ctrl #(
    .H_ACTIVE(4), .V_ACTIVE(2), .H_BLANK(2), .V_BLANK(1),
    .ADDR_W(20), .UNDERRUN_MAX(16'd3)
  ) dut (
    .clk(clk), .reset(reset),
    .buf0_full(buf0_full), .buf1_full(buf1_full),
    .r0(r0), .g0(g0), .b0(b0), .r1(r1), .g1(g1), .b1(b1),
    .re0(re0), .re1(re1), .rd_addr(rd_addr),
    .buf0_empty(buf0_empty), .buf1_empty(buf1_empty),
    .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b), .pix_valid(pix_valid),
    .hsync(hsync), .vsync(vsync), .frame_done(frame_done),
    .underrun_cnt(underrun_cnt)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Buffer contents as a function of address
  function automatic logic [23:0] mem0(input logic [19:0] a);
    return {a[7:0], ~a[7:0], 8'h00};
  endfunction
  function automatic logic [23:0] mem1(input logic [19:0] a);
    return {a[7:0] + 8'h80, a[7:0] ^ 8'h3C, 8'hFF};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Synchronous buffer model; each read queues the pixel it must become
  always @(posedge clk) begin
    if (!reset && re0) begin
      {r0, g0, b0} <= mem0(rd_addr);
      exp_q.push_back(mem0(rd_addr));
    end
    if (!reset && re1) begin
      {r1, g1, b1} <= mem1(rd_addr);
      exp_q.push_back(mem1(rd_addr));
    end
  end

  // Scoreboard: every valid pixel must match the oldest queued read
  always @(negedge clk) begin
    if (!reset && pix_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL pix_extra: got %0h expected no pixel at %0t", {pix_r, pix_g, pix_b}, $time);
      end else begin
        chk("pix", 32'({pix_r, pix_g, pix_b}), 32'(exp_q.pop_front()));
      end
    end
  end

  // Driver tasks
  task automatic do_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
  endtask

  // Entered at the negedge of the first re cycle; leaves at cycle 18.
  task automatic run_frame(input logic bsel, input int act_k, input logic b0v, input logic b1v);
    for (int k = 0; k < 18; k++) begin
      if (k == act_k) begin
        buf0_full = b0v;
        buf1_full = b1v;
      end
      chk("re_sel",     32'(bsel ? re1 : re0), 32'(fr[k].re));
      chk("re_other",   32'(bsel ? re0 : re1), 32'd0);
      if (fr[k].re) chk("rd_addr", 32'(rd_addr), 32'(fr[k].addr));
      chk("hsync",      32'(hsync),      32'(fr[k].hs));
      chk("vsync",      32'(vsync),      32'(fr[k].vs));
      chk("frame_done", 32'(frame_done), 32'(fr[k].fd));
      @(negedge clk);
    end
  endtask

  task automatic wait_frame_done();
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (frame_done) seen = 1'b1;
    end
    chk("frame_done_seen", 32'(seen), 32'd1);
  endtask

  initial begin
    // Expected per-cycle framing of one frame
    fr[0]  = '{1'b1, 20'd0, 1'b0, 1'b0, 1'b0};
    fr[1]  = '{1'b1, 20'd1, 1'b0, 1'b0, 1'b0};
    fr[2]  = '{1'b1, 20'd2, 1'b0, 1'b0, 1'b0};
    fr[3]  = '{1'b1, 20'd3, 1'b0, 1'b0, 1'b0};
    fr[4]  = '{1'b0, 20'd0, 1'b1, 1'b0, 1'b0};
    fr[5]  = '{1'b0, 20'd0, 1'b1, 1'b0, 1'b0};
    fr[6]  = '{1'b1, 20'd4, 1'b0, 1'b0, 1'b0};
    fr[7]  = '{1'b1, 20'd5, 1'b0, 1'b0, 1'b0};
    fr[8]  = '{1'b1, 20'd6, 1'b0, 1'b0, 1'b0};
    fr[9]  = '{1'b1, 20'd7, 1'b0, 1'b0, 1'b0};
    fr[10] = '{1'b0, 20'd0, 1'b1, 1'b0, 1'b0};
    fr[11] = '{1'b0, 20'd0, 1'b1, 1'b0, 1'b0};
    fr[12] = '{1'b0, 20'd0, 1'b0, 1'b1, 1'b0};
    fr[13] = '{1'b0, 20'd0, 1'b0, 1'b1, 1'b0};
    fr[14] = '{1'b0, 20'd0, 1'b0, 1'b1, 1'b0};
    fr[15] = '{1'b0, 20'd0, 1'b0, 1'b1, 1'b0};
    fr[16] = '{1'b0, 20'd0, 1'b0, 1'b1, 1'b0};
    fr[17] = '{1'b0, 20'd0, 1'b0, 1'b1, 1'b1};

    // Reset with buf0_full stuck high
    reset     = 1'b1;
    buf0_full = 1'b1;
    buf1_full = 1'b0;
    do_reset();
    chk("rst_re0",        32'(re0),          32'd0);
    chk("rst_re1",        32'(re1),          32'd0);
    chk("rst_rd_addr",    32'(rd_addr),      32'd0);
    chk("rst_buf0_empty", 32'(buf0_empty),   32'd1);
    chk("rst_buf1_empty", 32'(buf1_empty),   32'd1);
    chk("rst_pix_valid",  32'(pix_valid),    32'd0);
    chk("rst_pix",        32'({pix_r, pix_g, pix_b}), 32'd0);
    chk("rst_syncs",      32'({hsync, vsync, frame_done}), 32'd0);
    chk("rst_underrun",   32'(underrun_cnt), 32'd0);
    repeat (4) @(negedge clk);
    chk("stuck_full_re0",   32'(re0),        32'd0);
    chk("stuck_full_empty", 32'(buf0_empty), 32'd1);

    // Rising edge of buf0_full starts a scan of buffer 0
    buf0_full = 1'b0;
    @(negedge clk);
    buf0_full = 1'b1;
    @(negedge clk);
    chk("start_re0_not_yet", 32'(re0),        32'd0);
    chk("start_empty_still", 32'(buf0_empty), 32'd1);
    @(negedge clk);
    chk("start_buf0_empty", 32'(buf0_empty), 32'd0);
    run_frame(1'b0, 2, 1'b0, 1'b0);

    // Only buffer 0 filled: underrun at the first SWAP
    chk("und1_cnt",        32'(underrun_cnt), 32'd1);
    chk("und1_buf0_empty", 32'(buf0_empty),   32'(REP ? 1'b0 : 1'b1));
    chk("und1_re0",        32'(re0),          32'(REP));
    chk("und1_pix_valid",  32'(pix_valid),    32'd0);
    chk("pix_hold",        32'({pix_r, pix_g}), 32'({8'd7, 8'hF8}));
`ifndef REPEAT_FRAME_EN
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("idle_blank", 32'({re0, re1, pix_valid, hsync, vsync}), 32'd0);
    end
    buf0_full = 1'b1;
    @(negedge clk);
    @(negedge clk);
`endif

    // Buffer 1 becomes ready mid-frame: seamless switch at SWAP
    chk("f1_re0",        32'(re0),        32'd1);
    chk("f1_buf0_empty", 32'(buf0_empty), 32'd0);
    run_frame(1'b0, 3, 1'b0, 1'b1);
    chk("sw_re1",        32'(re1),          32'd1);
    chk("sw_rd_addr",    32'(rd_addr),      32'd0);
    chk("sw_buf0_empty", 32'(buf0_empty),   32'd1);
    chk("sw_buf1_empty", 32'(buf1_empty),   32'd0);
    chk("sw_underrun",   32'(underrun_cnt), 32'd1);
    run_frame(1'b1, 1, 1'b0, 1'b0);
    chk("und2_cnt",        32'(underrun_cnt), 32'd2);
    chk("und2_buf1_empty", 32'(buf1_empty),   32'(REP ? 1'b0 : 1'b1));
    chk("und2_re1",        32'(re1),          32'(REP));
    chk("und2_buf0_empty", 32'(buf0_empty),   32'd1);

    // Both ready together with last_sel = 1: buffer 0 first, then buffer 1
`ifdef REPEAT_FRAME_EN
    do_reset();
    @(negedge clk);
`endif
    buf0_full = 1'b1;
    buf1_full = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("both_pick_re0", 32'(re0), 32'd1);
    run_frame(1'b0, -1, 1'b1, 1'b1);
    chk("both_sw_re1",        32'(re1),        32'd1);
    chk("both_sw_rd_addr",    32'(rd_addr),    32'd0);
    chk("both_sw_buf0_empty", 32'(buf0_empty), 32'd1);
    chk("both_sw_buf1_empty", 32'(buf1_empty), 32'd0);

    // Reset during line 2 of ACTIVE
    repeat (7) @(negedge clk);
    reset     = 1'b1;
    buf0_full = 1'b0;
    buf1_full = 1'b0;
    @(negedge clk);
    chk("midrst_re",        32'({re0, re1}),               32'd0);
    chk("midrst_empties",   32'({buf0_empty, buf1_empty}), 32'd3);
    chk("midrst_pix_valid", 32'(pix_valid),                32'd0);
    chk("midrst_underrun",  32'(underrun_cnt),             32'd0);
    reset = 1'b0;
    exp_q.delete();

    // Repeated underruns: counter saturates at its limit
    for (int i = 0; i < 4; i++) begin
      buf0_full = 1'b0;
      @(negedge clk);
      buf0_full = 1'b1;
      wait_frame_done();
      @(negedge clk);
      chk("sat_underrun", 32'(underrun_cnt), 32'((i + 1 > 3) ? 3 : i + 1));
    end
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
